// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a show-ahead byte FIFO.
// Default framing is 8N1. Define UART_RX_PARITY_EN to receive 8E1 frames,
// which adds a parity check and drives the sticky parity_err flag.
module uart_rx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rx,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [7:0]             rd_data,
    output logic                   rx_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic          rx_s1_q, rx_s2_q;
    logic [1:0]    settle_q;
    logic          armed_q;
    logic [DW-1:0] divcnt_q;
    logic          tick;
    logic [2:0]    state_q, state_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          start_go, push, fe_set;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d, pe_set, parity_err_q;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q, rptr_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          empty, full, pop_ok, push_ok, ovr_set;
    logic          frame_err_q, overrun_q;

    // Two-flop synchronizer; settle_q marks when rx_s2_q carries a real line
    // value after reset. armed_q then waits for an idle-high line so a reset
    // in the middle of a frame never treats the still-low line as a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            rx_s1_q  <= rx;
            rx_s2_q  <= rx_s1_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && rx_s2_q) armed_q <= 1'b1;
        end
    end

    assign tick = (divcnt_q == DW'(DIV - 1));

    // Free-running 16x tick divider, realigned to the start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                divcnt_q <= '0;
        else if (start_go || tick)  divcnt_q <= '0;
        else                        divcnt_q <= divcnt_q + 1'b1;
    end

    // Receive FSM: start validation at mid-bit, then one sample per 16 ticks.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        start_go = 1'b0;
        push     = 1'b0;
        fe_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
        pe_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s2_q) begin
                    state_d  = S_START;
                    tcnt_d   = 4'd0;
                    start_go = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        if (rx_s2_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tcnt_d  = 4'd0;
                            bidx_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
                            perr_d  = 1'b0;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shreg_d = {rx_s2_q, shreg_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        perr_d  = (rx_s2_q != ^shreg_q);
                        state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        if (rx_s2_q) begin
`ifdef UART_RX_PARITY_EN
                            push   = !perr_q;
                            pe_set = perr_q;
`else
                            push   = 1'b1;
`endif
                            state_d = S_IDLE;
                        end else begin
                            fe_set  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and bit-timing registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            tcnt_q  <= 4'd0;
            bidx_q  <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
        end
    end

    // FIFO control: a pop on a full FIFO frees the slot the same-cycle push uses.
    assign empty   = (wptr_q == rptr_q);
    assign full    = ((wptr_q - rptr_q) == (AW + 1)'(DEPTH));
    assign pop_ok  = rd_en && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovr_set = push && full && !pop_ok;
    assign rptr_d  = rptr_q + {{AW{1'b0}}, pop_ok};

    // Next head value: the incoming byte when it lands at the head, otherwise
    // the stored entry at the new read pointer; hold when left empty.
    always_comb begin
        rd_data_d = rd_data_q;
        if (push_ok && (rptr_d == wptr_q))
            rd_data_d = shreg_q;
        else if (rptr_d != wptr_q)
            rd_data_d = mem_q[rptr_d[AW-1:0]];
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= shreg_q;
    end

    // Pointers and registered show-ahead head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= 8'd0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sticky error flags; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= fe_set  | (frame_err_q & ~err_clr);
            overrun_q   <= ovr_set | (overrun_q & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity-check state and its sticky flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_q       <= perr_d;
            parity_err_q <= pe_set | (parity_err_q & ~err_clr);
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = rd_data_q;
    assign rx_valid  = !empty;
    assign count     = wptr_q - rptr_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized/directed serial frames against a queue model of
// the FIFO; a passive monitor checks every popped byte against the model.
module tb_uart_rx_fifo;
    localparam int BAUD   = 115200;
    localparam int CLK_HZ = 16 * BAUD * 4;
    localparam int DEPTH  = 16;
    localparam int DIV    = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int BITCLK = 16 * DIV;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Clocks from the frame-start negedge to the negedge before the stop sample
    // edge: 2 sync clocks, then 8 ticks to mid-start and 16 per following bit.
    localparam int PUSH_NEG = 2 + DIV * (8 + 16 * (9 + NPAR));

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] count;
    logic          frame_err, overrun, parity_err;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_valid(rx_valid), .count(count),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_fe = 1'b0, exp_ovr = 1'b0, exp_pe = 1'b0;
    int         fe_events = 0;
    logic       fe_prev = 1'b0;
    logic       done;
    int         guard;
    logic [7:0] b;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name);
        chk({name, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
        chk({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({name, "_parity_err"}, 32'(parity_err), 32'(exp_pe));
    endtask

    // Monitor: every pop the DUT will take is checked against the model head.
    initial forever begin
        @(negedge clk);
        #1;
        if (frame_err && !fe_prev) fe_events++;
        fe_prev = frame_err;
        if (resetn && rd_en && rx_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
            end else begin
                chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BITCLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (BITCLK) @(negedge clk);
`else
        if (par) rx = 1'b0;
`endif
        rx = stop;
        repeat (BITCLK) @(negedge clk);
    endtask

    // A well-formed frame: the model stores it unless the FIFO is full.
    task automatic send_good(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovr = 1'b1;
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            rd_en = rx_valid;
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_fe = 1'b0; exp_ovr = 1'b0; exp_pe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_rd_data", 32'(rd_data), 0);
        chk("reset_rx_valid", 32'(rx_valid), 0);
        chk("reset_count", 32'(count), 0);
        chk_flags("reset");

        // Single byte
        send_good(8'h55);
        idle(BITCLK);
        chk("single_valid", 32'(rx_valid), 1);
        chk("single_count", 32'(count), 1);
        chk("single_head", 32'(rd_data), 32'h55);
        drain();
        chk("single_empty", 32'(rx_valid), 0);
        chk("single_count0", 32'(count), 0);

        // Overrun: 17 back-to-back bytes, no reads
        for (int i = 0; i <= 16; i++) send_good(8'(i));
        idle(BITCLK);
        chk("ovr_count", 32'(count), DEPTH);
        chk("ovr_head", 32'(rd_data), 0);
        chk_flags("ovr");
        drain();
        chk("ovr_drained", 32'(count), 0);
        pulse_clr();
        chk_flags("ovr_clr");

        // False start: 5-tick low glitch
        rx = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        idle(2 * BITCLK);
        chk("glitch_count", 32'(count), 0);
        chk_flags("glitch");
        send_good(8'hA3);
        idle(BITCLK);
        chk("glitch_next_count", 32'(count), 1);
        drain();

        // Framing error followed by a long break
        send_frame(8'h3C, ^8'h3C, 1'b0);
        exp_fe = 1'b1;
        chk_flags("frame");
        chk("frame_count", 32'(count), 0);
        pulse_clr();
        rx = 1'b0;
        repeat (20 * BITCLK) @(negedge clk);
        chk_flags("break_hold");
        chk("break_events", fe_events, 1);
        idle(BITCLK);
        send_good(8'h7E);
        idle(BITCLK);
        chk("break_next_count", 32'(count), 1);
        drain();
        chk("break_drained", 32'(count), 0);

        // Full FIFO with a pop on the push edge
        for (int i = 0; i < DEPTH; i++) send_good(8'($urandom));
        chk("full_count", 32'(count), DEPTH);
        b = 8'($urandom);
        exp_q.push_back(b);
        fork
            send_frame(b, ^b, 1'b1);
            begin
                repeat (PUSH_NEG) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        idle(BITCLK);
        chk("fullpop_count", 32'(count), DEPTH);
        chk_flags("fullpop");
        drain();
        chk("fullpop_drained", 32'(count), 0);

        // Random bytes, random gaps, concurrent random reader
        done = 1'b0;
        guard = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send_good(8'($urandom));
                    idle($urandom_range(0, 40));
                end
                idle(BITCLK);
                done = 1'b1;
            end
            begin
                while (!(done && !rx_valid) && guard < 20000) begin
                    rd_en = rx_valid && ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    guard++;
                end
                rd_en = 1'b0;
            end
        join
        chk("rand_reader_in_time", 32'(guard < 20000), 1);
        chk("rand_count", 32'(count), 0);
        chk("rand_model_empty", exp_q.size(), 0);
        chk_flags("rand");

`ifdef UART_RX_PARITY_EN
        // Parity: bad parity bit drops the byte, good one stores it
        send_frame(8'h01, 1'b0, 1'b1);
        exp_pe = 1'b1;
        idle(BITCLK);
        chk_flags("par_bad");
        chk("par_bad_count", 32'(count), 0);
        send_good(8'h01);
        idle(BITCLK);
        chk("par_good_count", 32'(count), 1);
        drain();
        pulse_clr();
        chk_flags("par_clr");
`endif

        // Reset in the middle of a data bit with a byte already buffered
        send_good(8'h5A);
        idle(BITCLK);
        chk("rst_pre_count", 32'(count), 1);
        fork
            send_frame(8'h00, 1'b0, 1'b1);
            begin
                repeat (3 * BITCLK + BITCLK / 2) @(negedge clk);
                resetn = 1'b0;
                exp_q.delete();
                exp_fe = 1'b0; exp_ovr = 1'b0; exp_pe = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_rd_data", 32'(rd_data), 0);
                chk("rst_count", 32'(count), 0);
                chk("rst_valid", 32'(rx_valid), 0);
                resetn = 1'b1;
            end
        join
        idle(2 * BITCLK);
        chk("rst_after_count", 32'(count), 0);
        chk("rst_after_valid", 32'(rx_valid), 0);
        chk_flags("rst_after");
        send_good(8'h99);
        idle(BITCLK);
        chk("rst_next_head", 32'(rd_data), 32'h99);
        drain();
        chk("rst_next_drained", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
